// File: rtl/cache_assoc.sv
// rtl/cache_assoc.sv - N-way set-associative cache line store with true-LRU and flush walker
//
// Ports:
//   clk         clock, all state updates on rising edge
//   rst         asynchronous active-low reset
//   addr        byte address: [1:0] ignored, word, set, tag from low to high
//   load        CPU read access, touches LRU on hit
//   store       refill word write; allocates victim way on miss
//   edit        CPU word write on hit, marks line dirty
//   invalid     invalidate addressed line on hit
//   flush       start whole-cache invalidate walk
//   din         write data
//   hit         addressed tag valid in some way (forced 0 while busy)
//   dout        word from hit way, 0 on miss
//   valid       valid bit of victim way of addressed set
//   dirty       dirty bit of victim way of addressed set
//   tag         tag stored in victim way
//   victim_way  way chosen for allocation
//   busy        flush in progress
module cache_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SET_BITS   = 5,
  parameter int WORD_BITS  = 3,
  localparam int TAG_W     = ADDR_WIDTH - SET_BITS - WORD_BITS - 2,
  localparam int WAY_W     = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  load,
  input  logic                  store,
  input  logic                  edit,
  input  logic                  invalid,
  input  logic                  flush,
  input  logic [31:0]           din,
  output logic                  hit,
  output logic [31:0]           dout,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAG_W-1:0]      tag,
  output logic [WAY_W-1:0]      victim_way,
  output logic                  busy
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_BITS;

  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [WAY_W-1:0] age_mem   [SETS][WAYS];
  logic [WAYS-1:0]  valid_mem [SETS];
  logic [WAYS-1:0]  dirty_mem [SETS];
  logic [31:0]      data_mem  [SETS][WAYS][WORDS];

  logic [SET_BITS-1:0]  fcnt;
  logic [SET_BITS-1:0]  set_idx;
  logic [WORD_BITS-1:0] word_idx;
  logic [TAG_W-1:0]     addr_tag;
  logic                 unused_addr;

  assign word_idx    = addr[2 +: WORD_BITS];
  assign set_idx     = addr[WORD_BITS + 2 +: SET_BITS];
  assign addr_tag    = addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused_addr = ^addr[1:0];

  logic [WAYS-1:0]  hit_vec;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_mem[set_idx][w] && (tag_mem[set_idx][w] == addr_tag) && !busy;
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    // Oldest way first, then overridden by the lowest-index invalid way if any.
    for (int w = 0; w < WAYS; w++) begin
      if (age_mem[set_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[set_idx][w]) victim = WAY_W'(w);
    end
  end

  assign hit        = |hit_vec;
  assign dout       = hit ? data_mem[set_idx][hit_way][word_idx] : 32'h0;
  assign victim_way = victim;
  assign valid      = valid_mem[set_idx][victim];
  assign dirty      = dirty_mem[set_idx][victim];
  assign tag        = tag_mem[set_idx][victim];

  // Single command decode with priority invalid > edit > store > load.
  logic do_inv, do_edit, do_store, do_load;
  logic wr_en, alloc, touch_en;
  logic [WAY_W-1:0] sel_way;

  assign do_inv   = !busy && invalid;
  assign do_edit  = !busy && !invalid && edit;
  assign do_store = !busy && !invalid && !edit && store;
  assign do_load  = !busy && !invalid && !edit && !store && load;
  assign sel_way  = hit ? hit_way : victim;
  assign wr_en    = (do_edit && hit) || do_store;
  assign alloc    = do_store && !hit;
  assign touch_en = (hit && (do_load || do_edit)) || do_store;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      fcnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w] <= '0;
          age_mem[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      if (busy) begin
        valid_mem[fcnt] <= '0;
        dirty_mem[fcnt] <= '0;
        for (int w = 0; w < WAYS; w++) age_mem[fcnt][w] <= WAY_W'(w);
        fcnt <= fcnt + 1'b1;
        if (fcnt == '1) busy <= 1'b0;
      end else if (flush) begin
        busy <= 1'b1;
        fcnt <= '0;
      end

      if (do_inv && hit) begin
        valid_mem[set_idx][hit_way] <= 1'b0;
        dirty_mem[set_idx][hit_way] <= 1'b0;
      end
      if (do_edit && hit) dirty_mem[set_idx][hit_way] <= 1'b1;
      if (alloc) begin
        tag_mem[set_idx][victim]   <= addr_tag;
        valid_mem[set_idx][victim] <= 1'b1;
        dirty_mem[set_idx][victim] <= 1'b0;
      end
      // Touch: ways younger than the touched way age by one, touched way becomes 0.
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way) age_mem[set_idx][w] <= '0;
          else if (age_mem[set_idx][w] < age_mem[set_idx][sel_way])
            age_mem[set_idx][w] <= age_mem[set_idx][w] + 1'b1;
        end
      end
    end
  end

  // Data array carries no reset; flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[set_idx][sel_way][word_idx] <= din;
  end

endmodule

// File: tb/tb_cache_assoc.sv
// tb/tb_cache_assoc.sv - self-checking bench for cache_assoc
module tb_cache_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        load = 1'b0, store = 1'b0, edit = 1'b0, invalid = 1'b0, flush = 1'b0;
  logic [31:0] din = '0;
  logic        hit;
  logic [31:0] dout;
  logic        valid, dirty;
  logic [21:0] tag;
  logic [0:0]  victim_way;
  logic        busy;

  int checks = 0;
  int failures = 0;

  cache_assoc dut (
    .clk(clk), .rst(rst), .addr(addr), .load(load), .store(store), .edit(edit),
    .invalid(invalid), .flush(flush), .din(din), .hit(hit), .dout(dout),
    .valid(valid), .dirty(dirty), .tag(tag), .victim_way(victim_way), .busy(busy)
  );

  always #5 clk = ~clk;

  // cmd bits: {invalid, edit, store, load}
  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] pa;
    logic        eh;
    logic [31:0] edout;
    logic        dchk;
    logic        ev;
    logic        ed;
    logic [21:0] et;
    logic        ew;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic cmd_cycle(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    {invalid, edit, store, load} = c;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    {invalid, edit, store, load} = 4'b0000;
  endtask

  initial begin
    vt[0]  = '{4'b0010, 32'h000, 32'h11111111, 32'h000, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 22'd0, 1'b1};
    vt[1]  = '{4'b0010, 32'h004, 32'h11111111, 32'h004, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 22'd0, 1'b1};
    vt[2]  = '{4'b0010, 32'h01C, 32'h11111111, 32'h01C, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 22'd0, 1'b1};
    vt[3]  = '{4'b0000, 32'h000, 32'h0,        32'h008, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 22'd0, 1'b1};
    vt[4]  = '{4'b0000, 32'h000, 32'h0,        32'h0B4, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 22'd0, 1'b0};
    vt[5]  = '{4'b0010, 32'h400, 32'h33333333, 32'h400, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0, 22'd0, 1'b0};
    vt[6]  = '{4'b0001, 32'h000, 32'h0,        32'h800, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 22'd1, 1'b1};
    vt[7]  = '{4'b0010, 32'h800, 32'h44444444, 32'h400, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 22'd0, 1'b0};
    vt[8]  = '{4'b0000, 32'h000, 32'h0,        32'h000, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 22'd0, 1'b0};
    vt[9]  = '{4'b0100, 32'h008, 32'h22222222, 32'h008, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, 22'd2, 1'b1};
    vt[10] = '{4'b0001, 32'h800, 32'h0,        32'h008, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 22'd0, 1'b0};
    vt[11] = '{4'b0100, 32'h1000, 32'h55555555, 32'h1000, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 22'd0, 1'b0};
    vt[12] = '{4'b0000, 32'h000, 32'h0,        32'h800, 1'b1, 32'h44444444, 1'b1, 1'b1, 1'b1, 22'd0, 1'b0};
    vt[13] = '{4'b1000, 32'h000, 32'h0,        32'h000, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 22'd0, 1'b0};
    vt[14] = '{4'b0000, 32'h000, 32'h0,        32'h800, 1'b1, 32'h44444444, 1'b1, 1'b0, 1'b0, 22'd0, 1'b0};
    vt[15] = '{4'b1100, 32'h800, 32'h66666666, 32'h800, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 22'd0, 1'b0};
    vt[16] = '{4'b0110, 32'h0B4, 32'h77777777, 32'h0B4, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 22'd0, 1'b0};

    // Reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst hit", 32'(hit), 32'd0);
    chk("rst dout", dout, 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst dirty", 32'(dirty), 32'd0);
    chk("rst tag", 32'(tag), 32'd0);
    chk("rst victim_way", 32'(victim_way), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven: apply command, then probe another address with commands idle
    for (int i = 0; i < 17; i++) begin
      cmd_cycle(vt[i].cmd, vt[i].a, vt[i].d);
      addr = vt[i].pa;
      #1;
      chk($sformatf("v%0d hit", i), 32'(hit), 32'(vt[i].eh));
      if (vt[i].dchk) chk($sformatf("v%0d dout", i), dout, vt[i].edout);
      chk($sformatf("v%0d valid", i), 32'(valid), 32'(vt[i].ev));
      chk($sformatf("v%0d dirty", i), 32'(dirty), 32'(vt[i].ed));
      chk($sformatf("v%0d tag", i), 32'(tag), 32'(vt[i].et));
      chk($sformatf("v%0d victim_way", i), 32'(victim_way), 32'(vt[i].ew));
    end

    // Store then load to same word in consecutive cycles
    cmd_cycle(4'b0010, 32'h0C0, 32'h9999AAAA);
    cmd_cycle(4'b0001, 32'h0C0, 32'h0);
    chk("st-ld hit", 32'(hit), 32'd1);
    chk("st-ld dout", dout, 32'h9999AAAA);

    // Full flush
    cmd_cycle(4'b0010, 32'h000, 32'hA0A0A0A0);
    cmd_cycle(4'b0010, 32'h0B4, 32'hB0B0B0B0);
    cmd_cycle(4'b0010, 32'h3E0, 32'hC0C0C0C0);
    addr = 32'h3E0;
    #1;
    chk("pre-flush hit 3E0", 32'(hit), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush busy start", 32'(busy), 32'd1);
    begin
      int n;
      n = 1;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        store = 1'b0;
        flush = 1'b0;
        if (!busy) break;
        n++;
        if (n == 5) begin
          addr = 32'h3E0;
          #1;
          chk("busy forces hit 0", 32'(hit), 32'd0);
        end
        if (n == 10) flush = 1'b1;
        if (n == 20) begin
          addr  = 32'h020;
          din   = 32'hDEADBEEF;
          store = 1'b1;
        end
      end
      chk("flush busy cycles", 32'(n), 32'd32);
    end
    addr = 32'h000; #1; chk("post-flush hit 000", 32'(hit), 32'd0);
    addr = 32'h0B4; #1; chk("post-flush hit 0B4", 32'(hit), 32'd0);
    addr = 32'h3E0; #1; chk("post-flush hit 3E0", 32'(hit), 32'd0);
    addr = 32'h0C0; #1; chk("post-flush hit 0C0", 32'(hit), 32'd0);
    addr = 32'h020; #1; chk("busy store ignored", 32'(hit), 32'd0);
    chk("post-flush valid", 32'(valid), 32'd0);

    // Reset in the middle of a flush
    cmd_cycle(4'b0010, 32'h000, 32'h12345678);
    cmd_cycle(4'b0010, 32'h3E0, 32'h87654321);
    addr = 32'h3E0;
    #1;
    chk("pre-abort hit 3E0", 32'(hit), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-flush busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hit 3E0", 32'(hit), 32'd0);
    chk("abort valid 3E0", 32'(valid), 32'd0);
    chk("abort tag 3E0", 32'(tag), 32'd0);
    chk("abort victim 3E0", 32'(victim_way), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    addr = 32'h000;
    #1;
    chk("abort hit 000", 32'(hit), 32'd0);
    chk("abort dout 000", dout, 32'd0);
    @(posedge clk);
    #1;
    chk("abort busy stays 0", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised N-way set-associative cache array for the cache-controller datapath, the successor of the direct-mapped line store. It holds data, tag, valid and dirty bits per line plus true-LRU ages per set, and presents the victim line's status so the controller can decide on write-back before refill. It also supports a multi-cycle whole-cache flush.

## Interface
- ADDR_WIDTH, 32, byte address width
- WAYS, 2, associativity; power of two, ≥2
- SET_BITS, 5, log2 of number of sets (SETS = 2^SET_BITS)
- WORD_BITS, 3, log2 of 32-bit words per line
- Derived: TAG_W = ADDR_WIDTH−SET_BITS−WORD_BITS−2 (22 at defaults); WAY_W = log2(WAYS)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  ADDR_WIDTH  byte address; [1:0] ignored, word = addr[WORD_BITS+1:2], set = next SET_BITS bits, tag = upper TAG_W bits
- load  in  1  CPU read access (LRU update on hit)
- store  in  1  refill word write from memory
- edit  in  1  CPU word write
- invalid  in  1  invalidate addressed line
- flush  in  1  start whole-cache invalidate
- din  in  32  write data
- hit  out  1  addressed tag present and valid in some way
- dout  out  32  word from hit way; 0 on miss
- valid, dirty  out  1 each  status of victim way of addressed set
- tag  out  TAG_W  tag stored in victim way
- victim_way  out  WAY_W  way chosen for allocation
- busy  out  1  flush in progress

## Operation
- Lookup combinational from addr: compare tag against all ways of set; at most one way matches (guaranteed by allocation rule).
- Victim: lowest-index invalid way in set; if all valid, the way with age WAYS−1.
- LRU: each way holds WAY_W-bit age; ages in a set are always a permutation of 0..WAYS−1. "Touch w": every way with age < age[w] increments, age[w] ← 0.
- Commands one-hot in intent; if several asserted, priority invalid > edit > store > load. All ignored while busy.
- load: hit → touch hit way. Miss → no change.
- edit: hit → write din to word, dirty ← 1, touch. Miss → no change.
- store: hit → write din to word, dirty unchanged, touch. Miss → in victim way: write din to word, tag ← addr tag, valid ← 1, dirty ← 0, touch. Other words of that line are stale until controller completes refill.
- invalid: hit → valid ← 0, dirty ← 0 for hit way, ages unchanged. Miss → no change.
- flush (busy=0): walk sets 0..SETS−1, one per cycle, clearing valid and dirty of all ways and restoring ages to reset value. Data RAM untouched. flush while busy ignored.

## Timing
- Reset (rst=0, asynchronous): all valid=0, dirty=0, ages of way i = i in every set, busy=0, flush counter=0. Outputs after reset for any addr: hit=0, dout=0, valid=0, dirty=0, tag=0, victim_way=0.
- Reads: zero latency; hit/dout/victim outputs combinational from addr and current state.
- Writes: take effect at the rising edge where the command is sampled; visible on outputs immediately after.
- Flush: sampled at edge t → busy=1 after t; set k cleared at edge t+1+k; busy=0 after edge t+SETS. hit forced 0 and commands ignored while busy=1.
- Reset mid-flush aborts it; end state identical to normal reset.
- store then load to same word in consecutive cycles: load sees new data.

## Test plan
- Reset: rst low 2 cycles, addr=0x0 → hit=0, dout=0, valid=0, dirty=0, tag=0, victim_way=0, busy=0.
- Refill: store din=0x11111111 at 0x000,0x004,0x01C → each then load hits with dout=0x11111111; 0x008 hits with stale data; 0x0B4 (set 5) misses, dout=0.
- LRU (WAYS=2): store 0x000 then 0x400 (both set 0); load 0x000; addr=0x800 → hit=0, victim_way=1, valid=1, tag=1; store 0x800 → subsequent 0x400 misses, 0x000 hits.
- Dirty: edit din=0x22222222 at 0x008 after refill → dout=0x22222222; make it victim (access other way) → dirty=1, tag=0; edit on miss 0x1000 changes nothing.
- Invalid: invalid at 0x000 → hit=0 next cycle, victim_way points to that way with valid=0, dirty=0.
- Flush (SET_BITS=5): fill several sets, pulse flush → busy high exactly 32 cycles, commands during busy ignored, afterwards all lookups miss; assert rst at cycle 10 of flush → busy=0 immediately, all invalid.
